// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the restoring divider.
//   div_state_e : controller states (idle, iterating, result held).
//   cnt_width() : bits needed for an iteration counter of a given operand width.
package div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem_i   : partial remainder (WIDTH+1 bits)
//   dvs_i   : divisor magnitude
//   bit_i   : next dividend bit, MSB first
//   rem_o   : updated partial remainder
//   q_bit_o : quotient bit produced by this iteration
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvs_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One extra bit above the shifted remainder gives a reliable borrow/sign bit.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, dvs_i};
    assign q_bit_o = ~diff[WIDTH+1];
    assign rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/div_restoring.sv
// div_restoring: sequential restoring divider, one quotient bit per clock.
//   clock, reset          : clock and asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b, is_signed sampled on acceptance)
//   out_valid / out_ready : result handshake (q, r, div_by_zero, overflow)
// Signed results truncate toward zero; the remainder takes the dividend's sign.
module div_restoring
    import div_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SIGNED_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned      CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    div_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;      // dividend bits, shifted out MSB first; quotient shifts in
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             zero_q;     // divide-by-zero operation pending
    logic             ovf_pend_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dbz_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic             signed_mode;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic             ovf_hit;
    logic             accept;
    logic [WIDTH:0]   step_rem;
    logic             step_q_bit;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    assign signed_mode = (SIGNED_EN != 0) && is_signed;
    assign a_neg       = signed_mode && a[WIDTH-1];
    assign b_neg       = signed_mode && b[WIDTH-1];
    assign a_abs       = a_neg ? -a : a;
    assign b_abs       = b_neg ? -b : b;
    assign b_zero      = (b == '0);
    assign ovf_hit     = signed_mode && (a == MostNeg) && (b == '1);

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .dvs_i  (dvs_q),
        .bit_i  (dvd_q[WIDTH-1]),
        .rem_o  (step_rem),
        .q_bit_o(step_q_bit)
    );

    // Magnitudes as they stand after the final iteration.
    assign q_mag = {dvd_q[WIDTH-2:0], step_q_bit};
    assign r_mag = step_rem[WIDTH-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_pend_q  <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            state_q     <= StCalc;
            cnt_q       <= '0;
            rem_q       <= '0;
            // A zero divisor reports the dividend untouched as the remainder.
            dvd_q       <= b_zero ? a : a_abs;
            dvs_q       <= b_abs;
            q_neg_q     <= a_neg ^ b_neg;
            r_neg_q     <= a_neg;
            zero_q      <= b_zero;
            ovf_pend_q  <= ovf_hit;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StCalc: begin
                    if (zero_q) begin
                        q_q         <= '1;
                        r_q         <= dvd_q;
                        dbz_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        rem_q <= step_rem;
                        dvd_q <= q_mag;
                        cnt_q <= cnt_q + CntW'(1);
                        if (cnt_q == LastCnt) begin
                            q_q         <= q_neg_q ? -q_mag : q_mag;
                            r_q         <= r_neg_q ? -r_mag : r_mag;
                            ovf_q       <= ovf_pend_q;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_restoring.sv
module tb_div_restoring;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    div_restoring #(
        .WIDTH    (W),
        .SIGNED_EN(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .r          (r),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } vec_t;

    localparam int NVec = 11;
    vec_t vecs[NVec];
    vec_t exp_q[$];
    vec_t mon_e;
    vec_t v_bp;
    vec_t v_next;
    vec_t v_after;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare on the cycle a result is actually consumed.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got q=%0h r=%0h expected none", q, r);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result_q", q, mon_e.q);
                chk("result_r", r, mon_e.r);
                chk("result_dbz", div_by_zero, mon_e.dbz);
                chk("result_ovf", overflow, mon_e.ovf);
            end
        end
    end

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        chk("idle_in_ready", in_ready, 1);
        a = v.a;
        b = v.b;
        is_signed = v.s;
        in_valid = 1'b1;
        exp_q.push_back(v);
        tick();
        in_valid = 1'b0;
        // Scramble inputs: they must not disturb the running operation.
        a = 8'($urandom);
        b = 8'($urandom);
        is_signed = 1'($urandom);
        if (v.b != 0) begin
            chk("busy_in_ready", in_ready, 0);
            chk("busy_out_valid", out_valid, 0);
        end
        wait_result(cyc);
        chk("latency", cyc, (v.b == 0) ? 1 : W);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consumed_out_valid", out_valid, 0);
        chk("q_hold_after_consume", q, v.q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        //          a      b      s     q      r      dbz   ovf
        vecs[0]  = '{8'd200, 8'd7,  1'b0, 8'd28,  8'd4,  1'b0, 1'b0};
        vecs[1]  = '{8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0};
        vecs[2]  = '{8'h07,  8'hFE, 1'b1, 8'hFD,  8'h01, 1'b0, 1'b0};
        vecs[3]  = '{8'h55,  8'h00, 1'b0, 8'hFF,  8'h55, 1'b1, 1'b0};
        vecs[4]  = '{8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 1'b1};
        vecs[5]  = '{8'h80,  8'hFF, 1'b0, 8'h00,  8'h80, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF,  8'h01, 1'b1, 8'hFF,  8'h00, 1'b0, 1'b0};
        vecs[7]  = '{8'h85,  8'h0A, 1'b1, 8'hF4,  8'hFD, 1'b0, 1'b0};
        vecs[8]  = '{8'hFF,  8'h10, 1'b0, 8'h0F,  8'h0F, 1'b0, 1'b0};
        vecs[9]  = '{8'h00,  8'h05, 1'b0, 8'h00,  8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h05,  8'h00, 1'b1, 8'hFF,  8'h05, 1'b1, 1'b0};
        v_bp    = '{8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0};
        v_next  = '{8'd100, 8'd10, 1'b0, 8'd10,  8'd0,  1'b0, 1'b0};
        v_after = '{8'd9,   8'd3,  1'b0, 8'd3,   8'd0,  1'b0, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        is_signed = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_flags", {div_by_zero, overflow}, 0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < NVec; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result must sit still while the consumer stalls.
        a = v_bp.a;
        b = v_bp.b;
        is_signed = v_bp.s;
        in_valid = 1'b1;
        exp_q.push_back(v_bp);
        tick();
        in_valid = 1'b0;
        wait_result(cyc);
        chk("bp_latency", cyc, W);
        for (int i = 0; i < 5; i++) begin
            chk("bp_q_stable", q, v_bp.q);
            chk("bp_r_stable", r, v_bp.r);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            tick();
        end
        // Consume and accept on the same edge.
        a = v_next.a;
        b = v_next.b;
        is_signed = v_next.s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(v_next);
        #1;
        chk("reload_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("reload_out_valid", out_valid, 0);
        chk("reload_busy", in_ready, 0);
        wait_result(cyc);
        chk("reload_latency", cyc, W);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the 4th iteration aborts the operation.
        a = 8'd200;
        b = 8'd7;
        is_signed = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_q", q, 0);
        chk("abort_r", r, 0);
        chk("abort_flags", {div_by_zero, overflow}, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        run_vec(v_after);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_restoring.md
# div_restoring

Parametrised sequential restoring divider, the successor to the fixed 8-bit divider. It computes quotient and remainder for signed or unsigned operands of width WIDTH, at one quotient bit per clock. Operands and results move over valid/ready handshakes, and divide-by-zero and signed overflow are flagged explicitly. It sits beside the ALU as a multi-cycle execution unit.

## Interface
- WIDTH, 8, operand/result width in bits; minimum 2.
- SIGNED_EN, 1, 1 honours the is_signed input; 0 ties the divider to unsigned mode.

- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces the block to its idle state.
- in_valid  input  1  operands presented.
- in_ready  output  1  the block can accept operands this cycle.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- is_signed  input  1  treat a and b as two's complement; sampled at acceptance.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- q  output  WIDTH  quotient.
- r  output  WIDTH  remainder.
- div_by_zero  output  1  the result came from b == 0.
- overflow  output  1  the result came from signed most-negative / -1.

## Operation
- States: IDLE, CALC, DONE.
- Acceptance occurs on an edge where in_valid && in_ready is high.
- in_ready = (state == IDLE) || (state == DONE && out_ready). A result may be consumed and a new operand pair accepted on the same edge.
- On acceptance with b != 0:
  - Latch |a| and |b|; the absolute value applies only when signed mode is active.
  - Latch the quotient sign (sign a XOR sign b) and the remainder sign (sign a).
  - Clear the partial remainder (WIDTH+1 bits) and the iteration counter.
  - Go to CALC.
- CALC, one iteration per edge:
  - Shift the next dividend bit into the partial remainder and trial-subtract |b|.
  - A non-negative difference keeps the difference and shifts in quotient bit 1; a negative difference restores the old value and shifts in 0.
  - After WIDTH iterations, apply sign correction (negate q if the quotient sign is set, negate r if the remainder sign is set), load q/r, and go to DONE.
- Signed semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Most-negative / -1 gives q = most-negative, r = 0, overflow = 1.
- On acceptance with b == 0:
  - Go to DONE on the next edge with no CALC phase.
  - q = all ones, r = a unmodified, div_by_zero = 1.
- DONE:
  - out_valid = 1, and q/r/flags are held stable.
  - out_ready moves the block to IDLE, or reloads it if in_valid is also high.
- Flags are cleared on each acceptance.
- q and r hold their last value after consumption.

## Timing
- Reset value of every output: in_ready = 1, out_valid = 0, q = 0, r = 0, div_by_zero = 0, overflow = 0. State = IDLE.
- Let the acceptance edge be E0.
  - Normal division: out_valid rises after edge E0+WIDTH. For WIDTH = 8 that is 8 CALC edges, so the result is visible in the cycle after E0+8.
  - Divide-by-zero: out_valid rises after edge E0+1.
- Back-to-back throughput: one result per WIDTH+1 cycles when out_ready is held high.
- During CALC, in_ready = 0 and out_valid = 0. Input changes during CALC have no effect.
- Reset asserted mid-CALC or mid-DONE: the operation is aborted with no partial result. All outputs take their reset values immediately, and in_ready = 1 in the first cycle after reset deasserts.
- out_ready while out_valid = 0 is ignored.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the counter width function clog2(WIDTH+1).
- Sub-module div_step is combinational and performs one restoring iteration: partial remainder in, divisor, next dividend bit -> new partial remainder and quotient bit.
- The top module owns the FSM, counter, sign handling and handshake.

## Test plan
- Unsigned, WIDTH=8: a=200, b=7 -> q=28, r=4, out_valid exactly after edge E0+8, no flags.
- Signed: a=0xF9 (-7), b=2 -> q=0xFD (-3), r=0xFF (-1); a=7, b=0xFE (-2) -> q=0xFD, r=1.
- Divide by zero: a=0x55, b=0 -> q=0xFF, r=0x55, div_by_zero=1, out_valid after E0+1.
- Signed overflow: a=0x80, b=0xFF -> q=0x80, r=0, overflow=1. Unsigned 0x80/0xFF -> q=0, r=0x80, overflow=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> q/r/flags stable and in_ready=0.
  - Then raise out_ready with in_valid=1 (a=100, b=10) -> new operands accepted on the same edge, next result q=10, r=0.
- Reset at the 4th CALC iteration -> all outputs at reset values at once and in_ready=1 after deassertion. A following 9/3 gives q=3, r=0.
